uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit byte channel between NREQ on-chip requesters (e.g. echo path, status reporter).
//  Round-robin arbitration at packet granularity; each grant is held until the requester's last byte.
//  An idle-timeout reclaims a stalled grant, and an optional inter-packet gap spaces packets on the line.
//  Sits between the requesters and the UART TX payload stream, clocked with the UART in the same clk domain.
// PARAMETERS
//  NREQ        2    number of requesters (2..8)
//  GAP_CYCLES  0    idle clk cycles forced after each packet (0 = none)
//  TIMEOUT     255  clk cycles a granted requester may hold valid low mid-packet before grant is revoked (>=1)
// PORTS
//  clk            in   1        system clock, rising edge
//  reset          in   1        synchronous, active-high
//  req_valid      in   NREQ     requester i has a byte
//  req_last       in   NREQ     byte from requester i is final byte of its packet
//  req_data       in   8*NREQ   byte of requester i at [8*i+7:8*i]
//  req_ready      out  NREQ     byte of requester i accepted this cycle
//  tx_valid       out  1        byte offered to UART TX
//  tx_payload     out  8        byte to UART TX
//  tx_ready       in   1        UART TX accepts byte
//  grant_id       out  clog2(NREQ)  currently/last granted requester
//  busy           out  1        state != IDLE
//  timeout_pulse  out  1        one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant_id=0, gap_cnt=0, idle_cnt=0; all outputs 0.
//  States: IDLE, XFER, GAP.
//  IDLE: when any req_valid, winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   Register grant_id=winner; go XFER next cycle (1-cycle arbitration latency). No valid -> stay.
//  XFER: combinational pass-through from granted i only:
//   tx_valid=req_valid[i], tx_payload=req_data[i], req_ready[i]=tx_ready&&req_valid[i].
//   All other req_ready=0; tx_valid/tx_payload=0 outside XFER.
//   Handshake (tx_valid&&tx_ready) with req_last[i]=1 -> rr_ptr=(i+1) mod NREQ; GAP if GAP_CYCLES>0, else IDLE.
//   Handshake with req_last=0 -> stay XFER, idle_cnt=0.
//   req_valid[i]=0 -> idle_cnt++. On idle_cnt==TIMEOUT-1 -> timeout_pulse=1, rr_ptr=(i+1) mod NREQ, GAP/IDLE as above.
//   req_valid[i]=1 without tx_ready -> no timeout counting (UART backpressure, idle_cnt holds).
//  GAP: gap_cnt counts 0..GAP_CYCLES-1, then IDLE. No ready/valid asserted. Arbitration resumes in IDLE.
//  Fairness: requester finishing a packet has lowest priority next round; single active requester re-granted
//   after IDLE cycle (+GAP).
//  Packet of one byte: req_last=1 on first byte; legal.
//  Non-granted requesters changing valid/data: ignored, never stall or corrupt current packet.
//  Reset mid-packet: abandons packet immediately, returns to reset state next cycle; no byte emitted on reset cycle.
//  Counters: idle_cnt width clog2(TIMEOUT+1), gap_cnt width clog2(GAP_CYCLES+1); never wrap (saturate at terminal).
//  rr_ptr increments modulo NREQ (non-power-of-2 NREQ legal).
// STRUCTURE
//  Shared package uart_pkg: state enum {IDLE,XFER,GAP}, UART byte width constant (8).
//  Sub-module rr_pick: combinational round-robin first-set-bit search (req vector, ptr) -> (any, idx);
//   reusable for other shared resources.
//  Top: FSM, counters, pass-through mux.
// TESTING
//  1) NREQ=2, only req0, 3-byte packet 0x41,0x42,0x43 last on 0x43, tx_ready=1
//     -> 1 IDLE cycle then 3 consecutive tx bytes, grant_id=0, busy falls after last.
//  2) Both requesters valid from reset, packets A(2 bytes) B(2 bytes)
//     -> order A0,A1,B0,B1; then A again (rr_ptr alternation over 4 packets).
//  3) Req1 mid-packet stalled while req0 valid, TIMEOUT=4
//     -> req1 valid low 4 cycles -> timeout_pulse once, grant moves to req0.
//  4) tx_ready held low 300 cycles with valid high, TIMEOUT=255
//     -> no timeout, byte held stable, accepted when tx_ready rises.
//  5) GAP_CYCLES=3, back-to-back single-byte packets from req0
//     -> exactly 3 GAP + 1 IDLE cycles between tx handshakes.
//  6) Assert reset during byte 2 of a 4-byte packet
//     -> all outputs 0 next cycle, rr_ptr=0, fresh arbitration after release.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared constants and FSM encoding for the UART TX arbiter slice.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t XFER = 2'd1;
  localparam state_t GAP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational round-robin search: first set bit of req starting at ptr.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // One extra bit so ptr+k never overflows before the modulo fold.
  logic [IW:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    // Descending scan: the candidate closest to ptr is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(N)) begin
        pos = pos - (IW + 1)'(N);
      end
      if (req[pos[IW-1:0]]) begin
        any = 1'b1;
        idx = pos[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : uart_tx_arbiter
// Purpose  : Packet-granular round-robin sharing of one UART TX byte channel,
//            with stalled-grant timeout and optional inter-packet gap.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_valid,
  output logic [BYTE_W-1:0]        tx_payload,
  input  logic                     tx_ready,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_pulse
);

  localparam int IW  = $clog2(NREQ);
  localparam int ICW = $clog2(TIMEOUT + 1);
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam state_t POST = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [ICW-1:0]  idle_cnt;
  logic [GCW-1:0]  gap_cnt;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [BYTE_W-1:0] req_bytes [NREQ];
  logic            g_valid;
  logic            g_last;
  logic [BYTE_W-1:0] g_data;
  logic            xfer_on;
  logic            hs;
  logic            end_pkt;
  logic            expire;
  logic [IW-1:0]   nxt_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign g_data  = req_bytes[grant_id];

  // Gated by reset so an abandoned packet cannot leak a byte on the reset cycle.
  assign xfer_on = (state == XFER) && !reset;

  always_comb begin
    tx_valid   = 1'b0;
    tx_payload = '0;
    req_ready  = '0;
    if (xfer_on) begin
      tx_valid   = g_valid;
      tx_payload = g_data;
      req_ready[grant_id] = g_valid && tx_ready;
    end
  end

  assign hs      = tx_valid && tx_ready;
  assign end_pkt = hs && g_last;
  assign expire  = (state == XFER) && !g_valid && (int'(idle_cnt) == TIMEOUT - 1);
  assign nxt_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      idle_cnt      <= '0;
      gap_cnt       <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            idle_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (end_pkt || expire) begin
            rr_ptr        <= nxt_ptr;
            idle_cnt      <= '0;
            gap_cnt       <= '0;
            timeout_pulse <= expire;
            state         <= POST;
          end else if (hs) begin
            idle_cnt <= '0;
          end else if (!g_valid && (int'(idle_cnt) < TIMEOUT)) begin
            // Valid-high with backpressure is not a stall: count only missing data.
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        GAP: begin
          if (int'(gap_cnt) >= GAP_CYCLES - 1) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter (two parameterisations).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic       g;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: GAP=0/TIMEOUT=255 instance, index 1: GAP=3/TIMEOUT=4 instance.
  logic       rst [2];
  logic       v   [2][2];
  logic       l   [2][2];
  logic [7:0] dat [2][2];
  logic       txr [2];
  logic [1:0] rdy [2];
  logic       txv [2];
  logic [7:0] txp [2];
  logic       gid [2];
  logic       bsy [2];
  logic       tmo [2];

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e0, e1;
  int   hc0 [$];
  int   hc1 [$];
  int   tc   [2];
  int   tcyc [2];
  int   total = 0;
  int   bad   = 0;

  uart_tx_arbiter #(.NREQ(2), .GAP_CYCLES(0), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(rst[0]),
    .req_valid({v[0][1], v[0][0]}), .req_last({l[0][1], l[0][0]}),
    .req_data({dat[0][1], dat[0][0]}), .req_ready(rdy[0]),
    .tx_valid(txv[0]), .tx_payload(txp[0]), .tx_ready(txr[0]),
    .grant_id(gid[0]), .busy(bsy[0]), .timeout_pulse(tmo[0])
  );

  uart_tx_arbiter #(.NREQ(2), .GAP_CYCLES(3), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(rst[1]),
    .req_valid({v[1][1], v[1][0]}), .req_last({l[1][1], l[1][0]}),
    .req_data({dat[1][1], dat[1][0]}), .req_ready(rdy[1]),
    .tx_valid(txv[1]), .tx_payload(txp[1]), .tx_ready(txr[1]),
    .grant_id(gid[1]), .busy(bsy[1]), .timeout_pulse(tmo[1])
  );

  always @(negedge clk) begin
    if (!rst[0] && txv[0] && txr[0]) begin
      hc0.push_back(cyc);
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL sb_a unexpected byte got=%02h gid=%0d want=none", txp[0], gid[0]);
      end else begin
        e0 = q0.pop_front();
        if (txp[0] !== e0.d || gid[0] !== e0.g) begin
          bad++;
          $display("FAIL sb_a got data=%02h gid=%0d want data=%02h gid=%0d",
                   txp[0], gid[0], e0.d, e0.g);
        end
      end
    end
    if (tmo[0]) begin tc[0]++; tcyc[0] = cyc; end
  end

  always @(negedge clk) begin
    if (!rst[1] && txv[1] && txr[1]) begin
      hc1.push_back(cyc);
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL sb_b unexpected byte got=%02h gid=%0d want=none", txp[1], gid[1]);
      end else begin
        e1 = q1.pop_front();
        if (txp[1] !== e1.d || gid[1] !== e1.g) begin
          bad++;
          $display("FAIL sb_b got data=%02h gid=%0d want data=%02h gid=%0d",
                   txp[1], gid[1], e1.d, e1.g);
        end
      end
    end
    if (tmo[1]) begin tc[1]++; tcyc[1] = cyc; end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b, input logic g);
    exp_t e;
    e.d = b;
    e.g = g;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic present(input int d, input int r, input logic [7:0] b, input logic last);
    v[d][r]   = 1'b1;
    l[d][r]   = last;
    dat[d][r] = b;
  endtask

  // Returns at posedge+1 right after the handshake edge.
  task automatic wait_hs(input int d, input int r);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy[d][r]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_hs dut=%0d req=%0d got=no_ready want=ready", d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int d, input int r, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      present(d, r, base + 8'(i), (i == n - 1));
      wait_hs(d, r);
    end
    v[d][r] = 1'b0;
    l[d][r] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    txr[d] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      v[d][r] = 1'b0; l[d][r] = 1'b0; dat[d][r] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_txv",   32'(txv[d]), 0);
    chk("rst_txp",   32'(txp[d]), 0);
    chk("rst_ready", 32'(rdy[d]), 0);
    chk("rst_busy",  32'(bsy[d]), 0);
    chk("rst_gid",   32'(gid[d]), 0);
    chk("rst_tmo",   32'(tmo[d]), 0);
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int stable_bad;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; txr[d] = 1'b1; tc[d] = 0; tcyc[d] = 0;
      for (int r = 0; r < 2; r++) begin
        v[d][r] = 1'b0; l[d][r] = 1'b0; dat[d][r] = 8'h00;
      end
    end

    // Single requester, 3-byte packet: one IDLE cycle, then back-to-back bytes.
    do_reset(0);
    hc0.delete();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b0);
    s = cyc;
    send_pkt(0, 0, 3, 8'h41);
    @(negedge clk);
    chk("t1_busy_after", 32'(bsy[0]), 0);
    chk("t1_nbytes", hc0.size(), 3);
    chk("t1_hs0_cyc", (hc0.size() > 0) ? hc0[0] - s : -1, 1);
    chk("t1_hs2_cyc", (hc0.size() > 2) ? hc0[2] - s : -1, 3);

    // Both requesters contend: packets alternate A,B,A,B.
    do_reset(0);
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h20, 1'b1); push(0, 8'h21, 1'b1);
    push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b0); push(0, 8'h22, 1'b1); push(0, 8'h23, 1'b1);
    fork
      begin send_pkt(0, 0, 2, 8'h10); send_pkt(0, 0, 2, 8'h12); end
      begin send_pkt(0, 1, 2, 8'h20); send_pkt(0, 1, 2, 8'h22); end
    join

    // Long backpressure must not trigger the timeout and must hold the byte.
    do_reset(0);
    tc[0] = 0;
    push(0, 8'h44, 1'b0);
    txr[0] = 1'b0;
    present(0, 0, 8'h44, 1'b1);
    @(posedge clk);
    #1;
    stable_bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!(txv[0] === 1'b1 && txp[0] === 8'h44 && tmo[0] === 1'b0 && rdy[0] === 2'b00))
        stable_bad++;
    end
    chk("t4_hold_stable", stable_bad, 0);
    @(posedge clk);
    #1;
    txr[0] = 1'b1;
    wait_hs(0, 0);
    v[0][0] = 1'b0;
    @(negedge clk);
    chk("t4_no_timeout", tc[0], 0);

    // Reset in the middle of a packet, after rr_ptr has moved to 1.
    do_reset(0);
    push(0, 8'h51, 1'b0);
    send_pkt(0, 0, 1, 8'h51);
    push(0, 8'h61, 1'b0);
    present(0, 0, 8'h61, 1'b0);
    wait_hs(0, 0);
    present(0, 0, 8'h62, 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t6_rst_txv",   32'(txv[0]), 0);
    chk("t6_rst_ready", 32'(rdy[0]), 0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    v[0][0] = 1'b0;
    @(negedge clk);
    chk("t6_post_busy", 32'(bsy[0]), 0);
    chk("t6_post_txv",  32'(txv[0]), 0);
    @(posedge clk);
    #1;
    push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b1);
    fork
      send_pkt(0, 0, 1, 8'h71);
      send_pkt(0, 1, 1, 8'h72);
    join

    // Stalled grant on req1 is revoked after TIMEOUT=4 idle cycles.
    do_reset(1);
    hc1.delete();
    tc[1] = 0;
    push(1, 8'h31, 1'b1); push(1, 8'h35, 1'b0);
    present(1, 1, 8'h31, 1'b0);
    wait_hs(1, 1);
    v[1][1] = 1'b0;
    present(1, 0, 8'h35, 1'b1);
    wait_hs(1, 0);
    v[1][0] = 1'b0;
    @(negedge clk);
    chk("t3_pulses", tc[1], 1);
    chk("t3_pulse_cyc", (hc1.size() > 0) ? tcyc[1] - hc1[0] : -1, 5);
    chk("t3_regrant_cyc", (hc1.size() > 1) ? hc1[1] - hc1[0] : -1, 9);

    // GAP_CYCLES=3: handshakes of back-to-back packets are 5 cycles apart.
    do_reset(1);
    hc1.delete();
    push(1, 8'h55, 1'b0); push(1, 8'h56, 1'b0);
    send_pkt(1, 0, 1, 8'h55);
    send_pkt(1, 0, 1, 8'h56);
    @(negedge clk);
    chk("t5_spacing", (hc1.size() > 1) ? hc1[1] - hc1[0] : -1, 5);

    repeat (4) @(posedge clk);
    chk("sb_a_drained", q0.size(), 0);
    chk("sb_b_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
